// File: rtl/axi_mst_gen.sv
// axi_mst_gen: AXI4 master traffic generator with read-back check.
// Each run writes NUM_BURST INCR bursts of BURST_LEN beats, starting at BASE_ADDR.
// After each write burst it reads the same burst back and compares every beat
// against the pattern (global beat index XOR 0xA5A5_A5A5).
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   start                 one-cycle pulse, starts a run when idle
//   busy, done            run in progress / one-cycle completion pulse
//   rd_data_err, err_cnt  sticky error flag / saturating count of bad beats and responses
//   aw*, w*, b*           write address, write data and write response channels
//   ar*, r*               read address and read data channels
module axi_mst_gen #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           BURST_LEN  = 8,
    parameter int unsigned           NUM_BURST  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_data_err,
    output logic [15:0]             err_cnt,
    // write address channel
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    // write data channel
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    // write response channel
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    // read address channel
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    // read data channel
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int unsigned STRB_W      = DATA_WIDTH / 8;
    localparam int unsigned SIZE_LOG2   = $clog2(STRB_W);
    localparam int unsigned BURST_BYTES = BURST_LEN * STRB_W;
    localparam int unsigned BURST_W     = (NUM_BURST > 1) ? $clog2(NUM_BURST) : 1;
    localparam int unsigned IDX_W       = 32;
    localparam int unsigned BEAT_W      = 8;

    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0]    LAST_BURST = BURST_W'(NUM_BURST - 1);
    localparam logic [DATA_WIDTH-1:0] PATTERN    = {(DATA_WIDTH / 32){32'hA5A5_A5A5}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_NEXT
    } state_t;

    state_t               state;
    logic [BURST_W-1:0]   burst_q;
    logic [IDX_W-1:0]     base_idx_q;   // global index of beat 0 of the current burst
    logic [BEAT_W-1:0]    beat_q;       // beat within the current W or R burst
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [IDX_W-1:0]     rd_idx_c;
    logic                 rlast_err_c;
    logic                 beat_err_c;
    logic                 err_hit_c;

    // Expected data for a given global beat index.
    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [IDX_W-1:0] idx);
        return DATA_WIDTH'(idx) ^ PATTERN;
    endfunction

    // Static burst attributes; write and read-back share the burst address.
    assign awlen   = 8'(BURST_LEN - 1);
    assign arlen   = 8'(BURST_LEN - 1);
    assign awsize  = 3'(SIZE_LOG2);
    assign arsize  = 3'(SIZE_LOG2);
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign wstrb   = '1;
    assign awaddr  = addr_q;
    assign araddr  = addr_q;

    // Per-handshake error detection on B and R. An rlast anomaly is judged only
    // up to the expected last beat, so a late rlast is counted just once.
    always_comb begin
        rd_idx_c    = base_idx_q + IDX_W'(beat_q);
        rlast_err_c = ((beat_q < LAST_BEAT) && rlast) || ((beat_q == LAST_BEAT) && !rlast);
        beat_err_c  = (rdata != beat_data(rd_idx_c)) || (rresp != 2'b00) || rlast_err_c;
        err_hit_c   = 1'b0;
        if (state == ST_B && bvalid && bready && bresp != 2'b00) begin
            err_hit_c = 1'b1;
        end
        if (state == ST_R && rvalid && rready && beat_err_c) begin
            err_hit_c = 1'b1;
        end
    end

    // Control FSM, channel outputs and error accounting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            burst_q     <= '0;
            base_idx_q  <= '0;
            beat_q      <= '0;
            addr_q      <= BASE_ADDR;
            wdata       <= '0;
            wlast       <= 1'b0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_data_err <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (err_hit_c) begin
                rd_data_err <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end

            case (state)
                ST_IDLE: begin
                    // busy is still high during the done cycle, so a start there is ignored
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start && !busy) begin
                        busy       <= 1'b1;
                        burst_q    <= '0;
                        base_idx_q <= '0;
                        addr_q     <= BASE_ADDR;
                        awvalid    <= 1'b1;
                        state      <= ST_AW;
                    end
                end

                ST_AW: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wdata   <= beat_data(base_idx_q);
                        wlast   <= (LAST_BEAT == '0);
                        beat_q  <= '0;
                        state   <= ST_W;
                    end
                end

                ST_W: begin
                    // next beat is loaded in the handshake cycle, keeping W bubble-free
                    if (wvalid && wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= ST_B;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            wdata  <= beat_data(base_idx_q + IDX_W'(beat_q) + 1'b1);
                            wlast  <= ((beat_q + 1'b1) == LAST_BEAT);
                        end
                    end
                end

                ST_B: begin
                    if (bvalid && bready) begin
                        bready  <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= ST_AR;
                    end
                end

                ST_AR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        beat_q  <= '0;
                        state   <= ST_R;
                    end
                end

                ST_R: begin
                    // the burst ends on the slave's rlast, wherever it lands
                    if (rvalid && rready) begin
                        beat_q <= beat_q + 1'b1;
                        if (rlast) begin
                            rready <= 1'b0;
                            state  <= ST_NEXT;
                        end
                    end
                end

                ST_NEXT: begin
                    if (burst_q == LAST_BURST) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        burst_q    <= burst_q + 1'b1;
                        base_idx_q <= base_idx_q + IDX_W'(BURST_LEN);
                        addr_q     <= addr_q + ADDR_WIDTH'(BURST_BYTES);
                        awvalid    <= 1'b1;
                        state      <= ST_AW;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mst_gen.sv
// Testbench for axi_mst_gen with default parameters: a behavioural AXI slave
// that stores written beats and returns them on read-back, with optional random
// stalls and injected faults, driven by a table of run scenarios plus a
// hand-written mid-run reset sequence.
module tb_axi_mst_gen;

    localparam int unsigned BL     = 8;
    localparam int unsigned NB     = 16;
    localparam int          BUDGET = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, rd_data_err;
    logic [15:0] err_cnt;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    always #5 clk = ~clk;

    axi_mst_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .rd_data_err(rd_data_err), .err_cnt(err_cnt),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // scenario configuration (written by the main process only)
    bit cfg_stall;
    int cfg_corrupt;
    int cfg_berr;
    int cfg_rlast;

    // slave bookkeeping (written by the slave process only)
    int          done_cnt, aw_cnt, ar_cnt, w_idx, b_cnt, r_cnt;
    int          addr_errs, wdata_errs, stab_errs;
    int          r_burst, r_beat, ridx;
    bit          b_pend, b_hold, r_active, r_hold;
    bit          aw_stall, w_stall, ar_stall, rde_pend;
    logic        rde_before, rde_after, wl_prev;
    logic [31:0] aw_prev, w_prev, ar_prev;
    logic [31:0] wmem [256];

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] pat(input int idx);
        return 32'(idx) ^ 32'hA5A5_A5A5;
    endfunction

    function automatic logic [31:0] exp_addr(input int n);
        return 32'(n * BL * 4);
    endfunction

    function automatic logic rdy();
        if (cfg_stall) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave: at each falling edge choose the values the next rising edge will
    // sample, then book the handshakes that edge will perform.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
                done_cnt = 0; aw_cnt = 0; ar_cnt = 0; w_idx = 0; b_cnt = 0; r_cnt = 0;
                addr_errs = 0; wdata_errs = 0; stab_errs = 0;
                r_burst = 0; r_beat = 0;
                b_pend = 0; b_hold = 0; r_active = 0; r_hold = 0;
                aw_stall = 0; w_stall = 0; ar_stall = 0; rde_pend = 0;
                rde_before = 1'b1; rde_after = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (aw_stall && (!awvalid || awaddr != aw_prev)) stab_errs++;
                if (w_stall && (!wvalid || wdata != w_prev || wlast != wl_prev)) stab_errs++;
                if (ar_stall && (!arvalid || araddr != ar_prev)) stab_errs++;
                if (rde_pend) begin
                    rde_after = rd_data_err;
                    rde_pend  = 0;
                end

                awready = rdy();
                wready  = rdy();
                arready = rdy();
                bvalid  = b_hold || (b_pend && rdy());
                bresp   = (b_cnt == cfg_berr) ? 2'b10 : 2'b00;
                rvalid  = r_hold || (r_active && rdy());
                ridx    = r_burst * BL + r_beat;
                rdata   = (ridx < 256) ? wmem[ridx] : 32'h0;
                if (ridx == cfg_corrupt) rdata = rdata ^ 32'h1;
                rresp   = 2'b00;
                rlast   = (r_beat == BL - 1) || (r_burst == cfg_rlast && r_beat == 5);

                if (rvalid && rready) begin
                    if (ridx == cfg_corrupt) begin
                        rde_before = rd_data_err;
                        rde_pend   = 1;
                    end
                    r_beat++;
                    if (rlast) begin
                        r_active = 0;
                        r_cnt++;
                    end
                    r_hold = 0;
                end else begin
                    r_hold = rvalid;
                end
                if (awvalid && awready) begin
                    if (awaddr != exp_addr(aw_cnt)) addr_errs++;
                    aw_cnt++;
                end
                aw_stall = awvalid && !awready;
                aw_prev  = awaddr;
                if (wvalid && wready) begin
                    if (wdata != pat(w_idx) || wlast != ((w_idx % BL) == BL - 1)) wdata_errs++;
                    if (w_idx < 256) wmem[w_idx] = wdata;
                    w_idx++;
                    if (wlast) b_pend = 1;
                end
                w_stall = wvalid && !wready;
                w_prev  = wdata;
                wl_prev = wlast;
                if (bvalid && bready) begin
                    b_pend = 0;
                    b_cnt++;
                    b_hold = 0;
                end else begin
                    b_hold = bvalid;
                end
                if (arvalid && arready) begin
                    if (araddr != exp_addr(ar_cnt)) addr_errs++;
                    r_burst  = ar_cnt;
                    r_beat   = 0;
                    r_active = 1;
                    ar_cnt++;
                end
                ar_stall = arvalid && !arready;
                ar_prev  = araddr;
            end
        end
    end

    typedef struct {
        string name;
        bit    stall;
        int    corrupt_idx;
        int    berr_burst;
        int    rlast_burst;
        bit    extra_start;
        int    exp_err;
        bit    exp_rde;
    } vec_t;

    vec_t vecs [7];

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic pulse_start(input string name);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input bit extra, output bit ok);
        int cyc;
        cyc = 0;
        ok  = 0;
        while (cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            if (done_cnt != 0) begin
                ok = 1;
                break;
            end
            start = extra && ((cyc % 40) == 0);
        end
        start = 0;
    endtask

    initial begin
        bit ok;
        int cyc;
        rst_n = 0; start = 0;
        cfg_stall = 0; cfg_corrupt = -1; cfg_berr = -1; cfg_rlast = -1;

        //         name              stall corrupt berr rlast extra err rde
        vecs[0] = '{"ideal",          0,   -1,     -1,  -1,   0,    0,  0};
        vecs[1] = '{"stall",          1,   -1,     -1,  -1,   0,    0,  0};
        vecs[2] = '{"corrupt_b0k3",   0,    3,     -1,  -1,   0,    1,  1};
        vecs[3] = '{"bresp_b2",       0,   -1,      2,  -1,   0,    1,  1};
        vecs[4] = '{"start_busy",     0,   -1,     -1,  -1,   1,    0,  0};
        vecs[5] = '{"stall_mixed",    1,   37,      9,  -1,   1,    2,  1};
        vecs[6] = '{"rlast_early_b4", 0,   -1,     -1,   4,   0,    1,  1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rde", 32'(rd_data_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("awlen", 32'(awlen), 32'd7);
        chk("arlen", 32'(arlen), 32'd7);
        chk("awsize", 32'(awsize), 32'd2);
        chk("arsize", 32'(arsize), 32'd2);
        chk("awburst", 32'(awburst), 32'd1);
        chk("arburst", 32'(arburst), 32'd1);
        chk("wstrb", 32'(wstrb), 32'hF);

        for (int i = 0; i < 7; i++) begin
            cfg_stall   = vecs[i].stall;
            cfg_corrupt = vecs[i].corrupt_idx;
            cfg_berr    = vecs[i].berr_burst;
            cfg_rlast   = vecs[i].rlast_burst;
            do_reset();
            pulse_start(vecs[i].name);
            wait_done(vecs[i].extra_start, ok);
            chk({vecs[i].name, "_done_in_budget"}, 32'(ok), 32'd1);
            repeat (10) @(posedge clk);
            @(negedge clk);
            chk({vecs[i].name, "_done_pulses"}, 32'(done_cnt), 32'd1);
            chk({vecs[i].name, "_busy_end"}, 32'(busy), 32'd0);
            chk({vecs[i].name, "_aw_bursts"}, 32'(aw_cnt), NB);
            chk({vecs[i].name, "_w_beats"}, 32'(w_idx), NB * BL);
            chk({vecs[i].name, "_b_resps"}, 32'(b_cnt), NB);
            chk({vecs[i].name, "_ar_bursts"}, 32'(ar_cnt), NB);
            chk({vecs[i].name, "_r_bursts"}, 32'(r_cnt), NB);
            chk({vecs[i].name, "_addr_errs"}, 32'(addr_errs), 32'd0);
            chk({vecs[i].name, "_wdata_errs"}, 32'(wdata_errs), 32'd0);
            chk({vecs[i].name, "_stable_errs"}, 32'(stab_errs), 32'd0);
            chk({vecs[i].name, "_err_cnt"}, 32'(err_cnt), 32'(vecs[i].exp_err));
            chk({vecs[i].name, "_rd_data_err"}, 32'(rd_data_err), 32'(vecs[i].exp_rde));
            if (vecs[i].corrupt_idx >= 0) begin
                chk({vecs[i].name, "_rde_before_bad_beat"}, 32'(rde_before), 32'd0);
                chk({vecs[i].name, "_rde_after_bad_beat"}, 32'(rde_after), 32'd1);
            end
        end

        // Reset for one cycle while burst 5 is in its W phase, then restart.
        cfg_stall = 0; cfg_corrupt = -1; cfg_berr = -1; cfg_rlast = -1;
        do_reset();
        pulse_start("midrst");
        cyc = 0;
        while (!(awvalid && awaddr == 32'hA0) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        while (!wvalid && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_reached_w5", 32'(wvalid && awaddr == 32'hA0), 32'd1);
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("midrst_awvalid", 32'(awvalid), 32'd0);
        chk("midrst_wvalid", 32'(wvalid), 32'd0);
        chk("midrst_arvalid", 32'(arvalid), 32'd0);
        chk("midrst_bready", 32'(bready), 32'd0);
        chk("midrst_rready", 32'(rready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        pulse_start("restart");
        chk("restart_awvalid", 32'(awvalid), 32'd1);
        chk("restart_awaddr", awaddr, 32'h0);
        wait_done(1'b0, ok);
        chk("restart_done_in_budget", 32'(ok), 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("restart_done_pulses", 32'(done_cnt), 32'd1);
        chk("restart_aw_bursts", 32'(aw_cnt), NB);
        chk("restart_w_beats", 32'(w_idx), NB * BL);
        chk("restart_addr_errs", 32'(addr_errs), 32'd0);
        chk("restart_wdata_errs", 32'(wdata_errs), 32'd0);
        chk("restart_err_cnt", 32'(err_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_mst_gen.md
AXI_MST_GEN -- requirements
Module: axi_mst_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (32 or 64).
REQ-003 SHALL have parameter BURST_LEN, default 8, beats per burst (1..16).
REQ-004 SHALL have parameter NUM_BURST, default 16, bursts per run.
REQ-005 SHALL have parameter BASE_ADDR, default 0, first burst address (burst-size aligned).
REQ-006 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  in  1  one-cycle pulse, begins a run when idle.
REQ-009 SHALL have ports busy / done  out  1 / 1  run in progress / one-cycle completion pulse.
REQ-010 SHALL have port rd_data_err  out  1  sticky mismatch/response error flag.
REQ-011 SHALL have port err_cnt  out  16  count of erroneous beats, saturating.
REQ-012 SHALL have AW ports awaddr(ADDR_WIDTH), awlen(8), awsize(3), awburst(2), awvalid out; awready in.
REQ-013 SHALL have W ports wdata(DATA_WIDTH), wstrb(DATA_WIDTH/8), wlast, wvalid out; wready in.
REQ-014 SHALL have B ports bresp(2), bvalid in; bready out.
REQ-015 SHALL have AR ports araddr, arlen, arsize, arburst, arvalid out; arready in.
REQ-016 SHALL have R ports rdata(DATA_WIDTH), rresp(2), rlast, rvalid in; rready out.

Function
REQ-017 SHALL implement FSM IDLE -> AW -> W -> B -> AR -> R -> NEXT, NEXT -> AW if bursts remain else IDLE with done=1 for one cycle.
REQ-018 SHALL leave IDLE only on start=1; start while busy SHALL be ignored.
REQ-019 SHALL drive awlen=arlen=BURST_LEN-1, awsize=arsize=log2(DATA_WIDTH/8), awburst=arburst=2'b01 (INCR), wstrb all ones.
REQ-020 SHALL use burst n address BASE_ADDR + n*BURST_LEN*DATA_WIDTH/8, n=0..NUM_BURST-1; same address for write and read-back of burst n.
REQ-021 SHALL drive beat data = global beat index (n*BURST_LEN+k) zero-extended, XOR 0xA5A5_A5A5 replicated to DATA_WIDTH.
REQ-022 SHALL hold every valid and its payload stable from assertion until the cycle valid&ready=1; valids SHALL NOT depend combinationally on ready.
REQ-023 SHALL assert awvalid on AW entry; leave AW the cycle after awvalid&awready.
REQ-024 SHALL present beats in W; advance beat on wvalid&wready; wlast=1 only on beat BURST_LEN-1; leave W after last handshake.
REQ-025 SHALL assert bready only in B; on bvalid&bready with bresp!=2'b00 set rd_data_err and increment err_cnt once.
REQ-026 SHALL issue AR as in REQ-023; assert rready only in R.
REQ-027 SHALL compare each rdata (rvalid&rready) with expected beat; mismatch or rresp!=2'b00 sets rd_data_err, err_cnt+1 (once per beat).
REQ-028 SHALL end R on rlast handshake; rlast early or missing at beat BURST_LEN-1 SHALL count one error and still end at rlast.
REQ-029 SHALL saturate err_cnt at 16'hFFFF; rd_data_err and err_cnt cleared only by reset.
REQ-030 SHALL tolerate ready asserted before valid and ready held continuously (one beat per cycle, no bubbles in W/R).
REQ-031 SHALL keep busy=1 from cycle after accepted start until the done cycle inclusive.

Reset
REQ-032 SHALL, with rst_n=0 at a rising edge, force state IDLE, all valids, bready, rready, busy, done, rd_data_err to 0, err_cnt to 0, counters to 0.
REQ-033 SHALL abort any run on reset mid-transaction without completing the burst; outputs reach REQ-032 values the cycle after the sampled reset edge.

Verification
REQ-034 Default params, ideal slave (ready always 1, OKAY) -> 16 write + 16 read bursts, addresses 0x00,0x20,..,0x1E0, done once, rd_data_err=0, err_cnt=0.
REQ-035 Slave deasserts wready/rready-side rvalid randomly -> awaddr/wdata stable while stalled, data order intact, err_cnt=0.
REQ-036 Slave corrupts rdata of beat 3 burst 0 -> rd_data_err=1 next cycle, err_cnt=1, run still completes with done pulse.
REQ-037 Slave returns bresp=2'b10 on burst 2 -> err_cnt=1, rd_data_err=1; read data matching -> err_cnt stays 1.
REQ-038 rst_n=0 for one cycle during W of burst 5 -> all valids 0, busy=0, err_cnt=0; new start restarts at BASE_ADDR.
REQ-039 start pulsed while busy -> ignored, exactly NUM_BURST bursts and one done pulse.
